// File: rtl/dac_channel_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : dac_channel_scheduler
// Brief    : Round-robin scheduler sharing one LTC2624 quad-DAC SPI link among
//            four sample sources. It builds the 32-bit write-and-update frame,
//            shifts it out MSB first and sequences the power-up dac_clr pulse.
// Revision : 1.0  initial release
// ============================================================================
module dac_channel_scheduler #(
   parameter int CLK_DIV    = 2,   // clk cycles per spi_sck half-period
   parameter int GAP_CYCLES = 4,   // clk cycles dac_cs held high between frames
   parameter int CLR_CYCLES = 8    // clk cycles dac_clr held low after reset
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [3:0]  ch_valid,
   input  logic [47:0] ch_data,
   output logic [3:0]  ch_ready,
   output logic        spi_mosi,
   output logic        spi_sck,
   output logic        dac_cs,
   output logic        dac_clr,
   output logic        busy,
   output logic        frame_done
);

   // One shared counter serves CLEAR, the SCK half-period divider and GAP,
   // so it is sized for the largest of the three terminal counts.
   localparam int C_MAX_AB  = (CLR_CYCLES > GAP_CYCLES) ? CLR_CYCLES : GAP_CYCLES;
   localparam int C_CNT_MAX = (C_MAX_AB > CLK_DIV) ? C_MAX_AB : CLK_DIV;
   localparam int C_CNT_W   = $clog2(C_CNT_MAX + 1);

   typedef enum logic [2:0] {
      S_CLEAR = 3'd0,
      S_IDLE  = 3'd1,
      S_LOAD  = 3'd2,
      S_SHIFT = 3'd3,
      S_GAP   = 3'd4
   } state_t;

   state_t               r_state;
   state_t               w_state_nxt;
   logic [C_CNT_W-1:0]   r_cnt;
   logic [5:0]           r_edge;      // sck edges emitted in this frame (0..63)
   logic                 r_sck;
   logic                 r_mosi;
   logic [31:0]          r_shift;
   logic [1:0]           r_rr_ptr;    // last granted channel

   logic                 w_any;
   logic [1:0]           w_gnt_idx;
   logic [1:0]           w_scan;
   logic [11:0]          w_sample;
   logic [31:0]          w_frame;
   logic                 w_last_clr;
   logic                 w_div_end;
   logic                 w_last_edge;
   logic                 w_gap_end;

   assign w_last_clr  = (r_cnt == C_CNT_W'(CLR_CYCLES - 1));
   assign w_div_end   = (r_cnt == C_CNT_W'(CLK_DIV - 1));
   assign w_gap_end   = (r_cnt == C_CNT_W'(GAP_CYCLES - 1));
   assign w_last_edge = (r_edge == 6'd63);

   // Round-robin pick: first valid channel after the last granted one.
   always_comb begin
      w_any     = 1'b0;
      w_gnt_idx = 2'd0;
      w_scan    = 2'd0;
      for (int k = 1; k <= 4; k++) begin
         w_scan = r_rr_ptr + 2'(k);
         if (!w_any && ch_valid[w_scan]) begin
            w_any     = 1'b1;
            w_gnt_idx = w_scan;
         end
      end
   end

   // Select the granted sample and assemble the write-and-update frame.
   always_comb begin
      w_sample = ch_data[11:0];
      case (w_gnt_idx)
         2'd0: w_sample = ch_data[11:0];
         2'd1: w_sample = ch_data[23:12];
         2'd2: w_sample = ch_data[35:24];
         2'd3: w_sample = ch_data[47:36];
         default: w_sample = ch_data[11:0];
      endcase
      w_frame = {8'h00, 4'b0011, 2'b00, w_gnt_idx, w_sample, 4'h0};
   end

   // State register; reset restarts the clear sequence and aborts any frame.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= S_CLEAR;
      else     r_state <= w_state_nxt;
   end

   // Next-state logic and state-decoded outputs.
   always_comb begin
      w_state_nxt = r_state;
      dac_clr     = 1'b1;
      dac_cs      = 1'b1;
      busy        = 1'b1;
      frame_done  = 1'b0;
      ch_ready    = 4'b0000;
      case (r_state)
         S_CLEAR: begin
            dac_clr = 1'b0;
            if (w_last_clr) w_state_nxt = S_IDLE;
         end
         S_IDLE: begin
            busy = 1'b0;
            if (w_any) begin
               ch_ready    = 4'b0001 << w_gnt_idx;
               w_state_nxt = S_LOAD;
            end
         end
         S_LOAD: begin
            w_state_nxt = S_SHIFT;
         end
         S_SHIFT: begin
            dac_cs = 1'b0;
            if (w_div_end && w_last_edge) w_state_nxt = S_GAP;
         end
         S_GAP: begin
            frame_done = (r_cnt == '0);
            if (w_gap_end) w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_CLEAR;
      endcase
   end

   // Counters, arbitration pointer and SPI shift datapath.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt    <= '0;
         r_edge   <= 6'd0;
         r_sck    <= 1'b0;
         r_mosi   <= 1'b0;
         r_shift  <= 32'd0;
         r_rr_ptr <= 2'd3;
      end else begin
         case (r_state)
            S_CLEAR: begin
               r_cnt <= w_last_clr ? '0 : r_cnt + C_CNT_W'(1);
            end
            S_IDLE: begin
               r_cnt  <= '0;
               r_edge <= 6'd0;
               r_sck  <= 1'b0;
               if (w_any) begin
                  r_shift  <= w_frame;
                  r_mosi   <= w_frame[31];
                  r_rr_ptr <= w_gnt_idx;
               end else begin
                  r_mosi <= 1'b0;
               end
            end
            S_LOAD: begin
               r_cnt <= '0;
            end
            S_SHIFT: begin
               if (w_div_end) begin
                  r_cnt  <= '0;
                  r_sck  <= ~r_sck;
                  r_edge <= w_last_edge ? 6'd0 : r_edge + 6'd1;
                  // Data advances only on a falling edge; the last one parks mosi low.
                  if (r_sck) begin
                     r_shift <= {r_shift[30:0], 1'b0};
                     r_mosi  <= w_last_edge ? 1'b0 : r_shift[30];
                  end
               end else begin
                  r_cnt <= r_cnt + C_CNT_W'(1);
               end
            end
            S_GAP: begin
               r_cnt  <= w_gap_end ? '0 : r_cnt + C_CNT_W'(1);
               r_sck  <= 1'b0;
               r_mosi <= 1'b0;
            end
            default: begin
               r_cnt <= '0;
            end
         endcase
      end
   end

   assign spi_sck  = r_sck;
   assign spi_mosi = r_mosi;

endmodule
`default_nettype wire
